// File: rtl/card_pkg.sv
// Shared definitions for the memory-card game logic.
// Card state codes, format-word widths, game FSM states and winner codes.
package card_pkg;

    localparam int SYM_W = 3;   // symbol bits per card
    localparam int FMT_W = 5;   // renderer word: {symbol, state}

    localparam logic [1:0] CARD_DOWN  = 2'b00;
    localparam logic [1:0] CARD_SEL   = 2'b01;
    localparam logic [1:0] CARD_MATCH = 2'b10;

    localparam logic [1:0] WIN_P0  = 2'b00;
    localparam logic [1:0] WIN_P1  = 2'b01;
    localparam logic [1:0] WIN_TIE = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_FIRST,
        ST_WAIT_SECOND,
        ST_COMPARE,
        ST_SHOW_MISMATCH,
        ST_GAME_OVER
    } game_state_t;

    function automatic logic [1:0] win_code(input logic [3:0] s0, input logic [3:0] s1);
        if (s0 > s1)      return WIN_P0;
        else if (s1 > s0) return WIN_P1;
        else              return WIN_TIE;
    endfunction

endpackage

// File: rtl/turn_timer.sv
// Turn timer: a prescaler dividing the clock down to seconds, and a
// seconds down-counter.
//   clk, rst_n  : clock, synchronous active-low reset
//   reload      : load TURN_SEC and clear the prescaler (wins over enable)
//   enable      : let the timer run this cycle
//   time_left   : seconds remaining (registered)
//   expire      : this cycle is the last one of the turn
module turn_timer #(
    parameter int CLK_PER_SEC = 25_000_000,
    parameter int TURN_SEC    = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       reload,
    input  logic       enable,
    output logic [3:0] time_left,
    output logic       expire
);

    localparam int PW = $clog2(CLK_PER_SEC + 1);

    logic [PW-1:0] presc_q;
    logic          wrap;

    assign wrap = (presc_q == PW'(CLK_PER_SEC - 1));

    // time_left saturates at 0 (possible when a select beats a timeout), so
    // expiry fires on any second boundary once one second or less remains.
    assign expire = enable && wrap && (time_left <= 4'd1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q   <= '0;
            time_left <= '0;
        end else if (reload) begin
            presc_q   <= '0;
            time_left <= 4'(TURN_SEC);
        end else if (enable) begin
            if (wrap) begin
                presc_q <= '0;
                if (time_left != 4'd0)
                    time_left <= time_left - 4'd1;
            end else begin
                presc_q <= presc_q + PW'(1);
            end
        end
    end

endmodule

// File: rtl/board_ctrl.sv
// Game-logic stage for the 4x4 memory card game.
// Holds card symbols/states, cursor, current player, scores and turn timer,
// and emits the per-card renderer word {symbol[2:0], state[1:0]}.
//   start                 : pulse, begin a new game (IDLE / GAME_OVER only)
//   layout[47:0]          : card i symbol at [3i+2:3i], latched on start
//   btn_left/right/up/down: cursor move pulses (left > right > up > down)
//   btn_sel               : flip the card under the cursor
//   card_fmt[79:0]        : card i word at [5i+4:5i]
//   cursor, player, score0, score1, time_left, game_over, winner
module board_ctrl
    import card_pkg::*;
#(
    parameter int N_CARDS         = 16,
    parameter int CLK_PER_SEC     = 25_000_000,
    parameter int TURN_SEC        = 15,
    parameter int MISMATCH_CYCLES = 25_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [47:0] layout,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_sel,
    output logic [79:0] card_fmt,
    output logic [3:0]  cursor,
    output logic        player,
    output logic [3:0]  score0,
    output logic [3:0]  score1,
    output logic [3:0]  time_left,
    output logic        game_over,
    output logic [1:0]  winner
);

    localparam int         DW        = $clog2(MISMATCH_CYCLES + 1);
    localparam logic [3:0] LAST_PAIR = 4'(N_CARDS / 2 - 1);

    game_state_t       state_q, state_d;
    logic [SYM_W-1:0]  sym_q [N_CARDS];
    logic [1:0]        cst_q [N_CARDS];
    logic [3:0]        cursor_q, cursor_d;
    logic [3:0]        first_q, second_q;
    logic [3:0]        score0_q, score1_q, matched_q;
    logic              player_q;
    logic [DW-1:0]     delay_q;

    logic do_start, move_en, sel_ok, cmp_match, cmp_miss;
    logic revert_pair, revert_first, toggle, reload, expire;
    logic sel_hit, timer_en;
    logic [1:0] row, col;

    assign sel_hit  = btn_sel && (cst_q[cursor_q] == CARD_DOWN);
    assign timer_en = (state_q == ST_WAIT_FIRST) || (state_q == ST_WAIT_SECOND);

    turn_timer #(
        .CLK_PER_SEC (CLK_PER_SEC),
        .TURN_SEC    (TURN_SEC)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .reload    (reload),
        .enable    (timer_en),
        .time_left (time_left),
        .expire    (expire)
    );

    // Cursor move: 2-bit row/col arithmetic gives the wrap for free.
    always_comb begin
        row = cursor_q[3:2];
        col = cursor_q[1:0];
        if (btn_left)       col = col - 2'd1;
        else if (btn_right) col = col + 2'd1;
        else if (btn_up)    row = row - 2'd1;
        else if (btn_down)  row = row + 2'd1;
        cursor_d = {row, col};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        do_start     = 1'b0;
        move_en      = 1'b0;
        sel_ok       = 1'b0;
        cmp_match    = 1'b0;
        cmp_miss     = 1'b0;
        revert_pair  = 1'b0;
        revert_first = 1'b0;
        toggle       = 1'b0;
        reload       = 1'b0;
        case (state_q)
            ST_IDLE, ST_GAME_OVER: begin
                if (start) begin
                    do_start = 1'b1;
                    reload   = 1'b1;
                    state_d  = ST_WAIT_FIRST;
                end
            end
            ST_WAIT_FIRST: begin
                move_en = 1'b1;
                if (sel_hit) begin
                    sel_ok  = 1'b1;
                    state_d = ST_WAIT_SECOND;
                end else if (expire) begin
                    toggle = 1'b1;
                    reload = 1'b1;
                end
            end
            ST_WAIT_SECOND: begin
                move_en = 1'b1;
                if (sel_hit) begin
                    sel_ok  = 1'b1;
                    state_d = ST_COMPARE;
                end else if (expire) begin
                    revert_first = 1'b1;
                    toggle       = 1'b1;
                    reload       = 1'b1;
                    state_d      = ST_WAIT_FIRST;
                end
            end
            ST_COMPARE: begin
                if (sym_q[first_q] == sym_q[second_q]) begin
                    cmp_match = 1'b1;
                    if (matched_q == LAST_PAIR) begin
                        state_d = ST_GAME_OVER;
                    end else begin
                        reload  = 1'b1;
                        state_d = ST_WAIT_FIRST;
                    end
                end else begin
                    cmp_miss = 1'b1;
                    state_d  = ST_SHOW_MISMATCH;
                end
            end
            ST_SHOW_MISMATCH: begin
                if (delay_q == '0) begin
                    revert_pair = 1'b1;
                    toggle      = 1'b1;
                    reload      = 1'b1;
                    state_d     = ST_WAIT_FIRST;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N_CARDS; i++) begin
                sym_q[i] <= '0;
                cst_q[i] <= CARD_DOWN;
            end
            cursor_q  <= '0;
            first_q   <= '0;
            second_q  <= '0;
            score0_q  <= '0;
            score1_q  <= '0;
            matched_q <= '0;
            player_q  <= 1'b0;
            delay_q   <= '0;
        end else if (do_start) begin
            for (int unsigned i = 0; i < N_CARDS; i++) begin
                sym_q[i] <= layout[SYM_W*i +: SYM_W];
                cst_q[i] <= CARD_DOWN;
            end
            cursor_q  <= '0;
            score0_q  <= '0;
            score1_q  <= '0;
            matched_q <= '0;
            player_q  <= 1'b0;
        end else begin
            if (move_en)
                cursor_q <= cursor_d;
            // Select uses the pre-move cursor even when a move fires too.
            if (sel_ok) begin
                cst_q[cursor_q] <= CARD_SEL;
                if (state_q == ST_WAIT_FIRST) first_q  <= cursor_q;
                else                          second_q <= cursor_q;
            end
            if (cmp_match) begin
                cst_q[first_q]  <= CARD_MATCH;
                cst_q[second_q] <= CARD_MATCH;
                matched_q       <= matched_q + 4'd1;
                if (player_q) score1_q <= score1_q + 4'd1;
                else          score0_q <= score0_q + 4'd1;
            end
            if (cmp_miss)
                delay_q <= DW'(MISMATCH_CYCLES - 1);
            else if (state_q == ST_SHOW_MISMATCH && delay_q != '0)
                delay_q <= delay_q - DW'(1);
            if (revert_pair) begin
                cst_q[first_q]  <= CARD_DOWN;
                cst_q[second_q] <= CARD_DOWN;
            end
            if (revert_first)
                cst_q[first_q] <= CARD_DOWN;
            if (toggle)
                player_q <= ~player_q;
        end
    end

    always_comb begin
        card_fmt = '0;
        for (int unsigned i = 0; i < N_CARDS; i++)
            card_fmt[FMT_W*i +: FMT_W] = {sym_q[i], cst_q[i]};
    end

    assign cursor    = cursor_q;
    assign player    = player_q;
    assign score0    = score0_q;
    assign score1    = score1_q;
    assign game_over = (state_q == ST_GAME_OVER);
    assign winner    = game_over ? win_code(score0_q, score1_q) : WIN_P0;

endmodule

// File: doc/board_ctrl.md
Name: board_ctrl

Overview:
- Game-logic stage for the 4x4 memory card game.
- Holds the per-card symbol and visibility state, cursor, current player, scores and turn timer.
- Produces the 5-bit per-card format word consumed directly by the card renderer: [4:2] symbol, [1:0] state.
- Sits between the debounced button inputs and the VGA drawing stages.

Parameters:
- N_CARDS, 16, number of cards on the 4x4 grid; fixed to 16 in this revision.
- CLK_PER_SEC, 25_000_000, clock cycles per timer second.
- TURN_SEC, 15, seconds allowed per turn.
- MISMATCH_CYCLES, 25_000_000, cycles a mismatched pair stays face-up.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle pulse: begin a new game.
- layout  in  48  symbol per card, 3 bits each, card i at [3i+2:3i]; latched on an accepted start.
- btn_left / btn_right / btn_up / btn_down  in  1 each  one-cycle pulses that move the cursor.
- btn_sel  in  1  one-cycle pulse that flips the card under the cursor.
- card_fmt  out  80  card i format at [5i+4:5i].
- cursor  out  4  cursor index, row-major (row = cursor[3:2], col = cursor[1:0]).
- player  out  1  current player.
- score0, score1  out  4 each  pairs won per player.
- time_left  out  4  seconds remaining in the current turn.
- game_over  out  1  high in GAME_OVER.
- winner  out  2  00 = player 0, 01 = player 1, 10 = tie; valid only when game_over is high.

Behaviour:
- Card state encoding: 00 face-down, 01 selected (symbol shown with border), 10 matched (symbol shown), 11 unused and never produced.
- Reset, or rst_n low at any cycle including mid-game, forces:
  - FSM = IDLE; all card states = 00; latched symbols = 0; card_fmt = 0.
  - cursor = 0, player = 0, score0 = score1 = 0, time_left = 0.
  - game_over = 0, winner = 00; all counters cleared.
- All outputs are registered; each takes effect the cycle after the causing event.
- FSM states: IDLE, WAIT_FIRST, WAIT_SECOND, COMPARE, SHOW_MISMATCH, GAME_OVER.
- IDLE / GAME_OVER, on start:
  - latch layout; all states 00; cursor 0; scores 0; player 0; matched 0.
  - time_left = TURN_SEC, prescaler cleared; go to WAIT_FIRST.
  - start is ignored in every other state.
- Cursor movement (WAIT_FIRST and WAIT_SECOND only):
  - left/right wrap within the row; up/down wrap within the column.
  - Several direction pulses in one cycle: only the highest priority applies, left > right > up > down.
- Select, same cycle as a move: the select acts on the pre-move cursor and the move still applies.
- WAIT_FIRST: sel on a card in state 00 sets it to 01, records first_idx, goes to WAIT_SECOND. sel on a card in state 01 or 10 is ignored.
- WAIT_SECOND: sel on a card in state 00 sets it to 01, records second_idx, goes to COMPARE.
- COMPARE (exactly 1 cycle), symbols equal:
  - both cards go to 10; the current player's score +1; matched +1.
  - matched reaches 8: go to GAME_OVER.
  - otherwise go to WAIT_FIRST with the timer reloaded; the same player keeps the turn.
- COMPARE, symbols differ: load the delay counter with MISMATCH_CYCLES-1 and go to SHOW_MISMATCH. The timer is frozen.
- SHOW_MISMATCH: when the counter reaches 0, both cards return to 00, player toggles, timer reloads, go to WAIT_FIRST. Total time face-up in SHOW_MISMATCH = MISMATCH_CYCLES cycles.
- Turn timer:
  - runs only in WAIT_FIRST and WAIT_SECOND.
  - the prescaler wraps at CLK_PER_SEC-1 and decrements time_left on wrap.
- Timeout (time_left = 1 when the prescaler wraps):
  - in WAIT_SECOND, the first card reverts to 00.
  - player toggles; timer reloads to TURN_SEC; go to WAIT_FIRST.
- sel and timeout in the same cycle: sel wins and no timeout occurs.
- Scores are 4-bit and cannot overflow, since the maximum is 8.
- GAME_OVER: game_over = 1; winner is compared from the scores; card states hold.

Decomposition:
- Shared package card_pkg holds:
  - card state constants CARD_DOWN / CARD_SEL / CARD_MATCH;
  - SYM_W = 3 and FMT_W = 5;
  - the FSM enum;
  - winner codes.
- One sub-module, turn_timer: prescaler plus seconds down-counter with inputs reload / enable and outputs time_left / expire.

Test Plan:
All cases run with CLK_PER_SEC=4, TURN_SEC=3, MISMATCH_CYCLES=5. Layout has card i symbol = i>>1, so pairs are (0,1), (2,3), …

- Reset mid-game: after one card is selected, hold rst_n low one cycle. Expect card_fmt = 0, cursor 0, all scores 0, FSM IDLE. A following start is accepted.
- Match: start, sel at card 0, right, sel at card 1. Expect card_fmt[4:0] = 00010 and card_fmt[9:5] = 00010, score0 = 1, player still 0.
- Mismatch: cursor 0 sel, cursor 2 sel.
  - Expect both in state 01 for exactly 5 cycles after COMPARE.
  - Then both 00 and player = 1.
- Timeout plus wrap:
  - left from cursor 0 gives cursor 3; up from 0 gives 12.
  - Select one card, then idle 12 cycles: the card reverts to 00, player toggles, time_left = 3.
- Priority and collisions:
  - left+down together: only left applies.
  - sel on a matched card: no change.
  - sel in the same cycle as expiry in WAIT_SECOND: COMPARE entered, no player toggle.
- Full game: player 0 matches all 8 pairs. Expect game_over = 1, winner = 00, score0 = 8. A start pulse then restarts with scores 0.
